// File: rtl/pll_lock_seq_pkg.sv
// -----------------------------------------------------------------------------
// pll_lock_seq_pkg
// Shared definitions for the PLL lock monitor / reset sequencer:
//   - state_e   : FSM state encoding (WAIT/STABLE/RUN/HOLD, 2 bits)
//   - clog2     : ceiling log2, usable in constant expressions
//   - DEF_*     : default values of the sequencer parameters
// -----------------------------------------------------------------------------
package pll_lock_seq_pkg;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_STABLE = 2'd1,
    ST_RUN    = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_HOLD_CYCLES   = 16;

  // Smallest r with 2**r >= value; written as a bounded loop so it can be
  // evaluated at elaboration time.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pll_lock_seq_sync_bit.sv
// -----------------------------------------------------------------------------
// sync_bit
// N-stage single-bit synchronizer for asynchronous status inputs.
// Ports:
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset, clears the whole chain to 0
//   i_d     : asynchronous input bit
//   o_q     : synchronized output (last stage of the chain)
// -----------------------------------------------------------------------------
module sync_bit #(
  parameter int N = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [N-1:0] r_chain;

  // Shift the async bit through the flop chain; stage 0 may go metastable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= {N{1'b0}};
    end else begin
      r_chain <= {r_chain[N-2:0], i_d};
    end
  end

  assign o_q = r_chain[N-1];

endmodule

// File: rtl/pll_lock_seq.sv
// -----------------------------------------------------------------------------
// pll_lock_seq
// Lock monitor and reset sequencer for the 2x PLL. Runs on the board
// reference clock so it keeps working while the PLL is unlocked. Releases
// sys_rst only after the synchronized lock flag has been high for
// STABLE_CYCLES consecutive cycles; on a lock loss in RUN it re-asserts
// sys_rst for at least HOLD_CYCLES and counts the event.
//
// Ports:
//   CLK           : board reference clock, free-running
//   RST_n         : asynchronous active-low reset
//   locked        : PLL lock flag, asynchronous to CLK
//   clr_loss_cnt  : one-cycle synchronous clear of the loss counter
//   sys_rst       : active-high reset to PLL-clocked logic (registered)
//   lock_ok       : high only in RUN (registered)
//   lock_loss_cnt : saturating count of lock losses seen in RUN
//   state         : current FSM state, for debug
//
// Build option: define PLL_LOCK_LOSS_CNT_EN to build the lock-loss counter
// and its clear. Without it lock_loss_cnt reads 0 and clr_loss_cnt is
// ignored; the sequencing itself is identical.
// -----------------------------------------------------------------------------
module pll_lock_seq
  import pll_lock_seq_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int CNT_W         = 8
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             locked,
  input  logic             clr_loss_cnt,
  output logic             sys_rst,
  output logic             lock_ok,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [1:0]       state
);

  localparam int TMAX = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int TW   = clog2(TMAX);

  localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TCNT_ONE    = TW'(1);
  localparam logic [TW-1:0] TCNT_ZERO   = TW'(0);

  logic          w_lk_s;
  state_e        r_state;
  state_e        w_next_state;
  logic [TW-1:0] r_tcnt;
  logic [TW-1:0] w_next_tcnt;
  logic          w_loss;
  logic          r_sys_rst;
  logic          r_lock_ok;

  sync_bit #(
    .N (SYNC_STAGES)
  ) u_sync_locked (
    .i_clk   (CLK),
    .i_rst_n (RST_n),
    .i_d     (locked),
    .o_q     (w_lk_s)
  );

  // Next-state, shared timer and loss-event decode.
  always_comb begin
    w_next_state = r_state;
    w_next_tcnt  = r_tcnt;
    w_loss       = 1'b0;
    case (r_state)
      ST_WAIT: begin
        w_next_tcnt = TCNT_ZERO;
        if (w_lk_s) begin
          w_next_state = ST_STABLE;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_STABLE: begin
        // Any dropout restarts the full qualification window; not a loss.
        if (!w_lk_s) begin
          w_next_state = ST_WAIT;
          w_next_tcnt  = TCNT_ZERO;
        end else if (r_tcnt == STABLE_LAST) begin
          w_next_state = ST_RUN;
          w_next_tcnt  = TCNT_ZERO;
        end else begin
          w_next_tcnt  = r_tcnt + TCNT_ONE;
        end
      end
      ST_RUN: begin
        if (!w_lk_s) begin
          w_next_state = ST_HOLD;
          w_next_tcnt  = TCNT_ZERO;
          w_loss       = 1'b1;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_HOLD: begin
        // Lock flag deliberately ignored so the hold time is always served.
        if (r_tcnt == HOLD_LAST) begin
          w_next_state = ST_WAIT;
          w_next_tcnt  = TCNT_ZERO;
        end else begin
          w_next_tcnt  = r_tcnt + TCNT_ONE;
        end
      end
      default: begin
        w_next_state = ST_WAIT;
        w_next_tcnt  = TCNT_ZERO;
      end
    endcase
  end

  // State, timer and glitch-free outputs decoded from the next state.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state   <= ST_WAIT;
      r_tcnt    <= TCNT_ZERO;
      r_sys_rst <= 1'b1;
      r_lock_ok <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_tcnt    <= w_next_tcnt;
      r_sys_rst <= (w_next_state != ST_RUN);
      r_lock_ok <= (w_next_state == ST_RUN);
    end
  end

  assign sys_rst = r_sys_rst;
  assign lock_ok = r_lock_ok;
  assign state   = r_state;

`ifdef PLL_LOCK_LOSS_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_loss_cnt;

  // Saturating loss counter; a clear in the same cycle as a loss yields 1.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_loss_cnt <= {CNT_W{1'b0}};
    end else if (clr_loss_cnt && w_loss) begin
      r_loss_cnt <= CNT_ONE;
    end else if (clr_loss_cnt) begin
      r_loss_cnt <= {CNT_W{1'b0}};
    end else if (w_loss && (r_loss_cnt != CNT_MAX)) begin
      r_loss_cnt <= r_loss_cnt + CNT_ONE;
    end else begin
      r_loss_cnt <= r_loss_cnt;
    end
  end

  assign lock_loss_cnt = r_loss_cnt;
`else
  logic w_unused_cnt;

  assign w_unused_cnt  = clr_loss_cnt ^ w_loss;
  assign lock_loss_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pll_lock_seq.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_seq
// Directed bench for pll_lock_seq with STABLE_CYCLES=8, HOLD_CYCLES=4,
// SYNC_STAGES=2, CNT_W=4. Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point, so "edge k" below means the k-th
// rising edge after the stimulus change.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pll_lock_seq;

  localparam int SYNC_STAGES   = 2;
  localparam int STABLE_CYCLES = 8;
  localparam int HOLD_CYCLES   = 4;
  localparam int CNT_W         = 4;

  logic             CLK;
  logic             RST_n;
  logic             locked;
  logic             clr_loss_cnt;
  logic             sys_rst;
  logic             lock_ok;
  logic [CNT_W-1:0] lock_loss_cnt;
  logic [1:0]       state;

  int n_checks;
  int n_errors;
  int exp_cnt;

  pll_lock_seq #(
    .SYNC_STAGES   (SYNC_STAGES),
    .STABLE_CYCLES (STABLE_CYCLES),
    .HOLD_CYCLES   (HOLD_CYCLES),
    .CNT_W         (CNT_W)
  ) dut (
    .CLK           (CLK),
    .RST_n         (RST_n),
    .locked        (locked),
    .clr_loss_cnt  (clr_loss_cnt),
    .sys_rst       (sys_rst),
    .lock_ok       (lock_ok),
    .lock_loss_cnt (lock_loss_cnt),
    .state         (state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Counter value the build should show: model value when the counter is built.
  function automatic logic [31:0] exp_view();
`ifdef PLL_LOCK_LOSS_CNT_EN
    return 32'(exp_cnt);
`else
    return 32'd0;
`endif
  endfunction

  // From RUN: drop lock for the loss, restore it right after detection,
  // and return once the sequencer is back in RUN (edge 16).
  task automatic loss_and_relock(input string tag);
    locked = 1'b0;
    tick(3);
    exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
    check_eq({tag, "_hold_state"}, 32'(state), 32'd3);
    check_eq({tag, "_cnt"}, 32'(lock_loss_cnt), exp_view());
    locked = 1'b1;
    tick(13);
    check_eq({tag, "_run_state"}, 32'(state), 32'd2);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    exp_cnt      = 0;
    RST_n        = 1'b0;
    locked       = 1'b0;
    clr_loss_cnt = 1'b0;

    // ---------------- reset values ----------------
    tick(2);
    check_eq("rst_sys_rst", 32'(sys_rst), 32'd1);
    check_eq("rst_lock_ok", 32'(lock_ok), 32'd0);
    check_eq("rst_state",   32'(state),   32'd0);
    check_eq("rst_cnt",     32'(lock_loss_cnt), 32'd0);

    // ---------------- power-up with locked=0 for 100 cycles ----------------
    RST_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      check_eq("pwr_sys_rst", 32'(sys_rst), 32'd1);
      check_eq("pwr_lock_ok", 32'(lock_ok), 32'd0);
      check_eq("pwr_state",   32'(state),   32'd0);
    end

    // ---------------- clean lock: release at edge 11 ----------------
    locked = 1'b1;
    tick(3);
    check_eq("lock_e3_state", 32'(state), 32'd1);
    tick(7);
    check_eq("lock_e10_sys_rst", 32'(sys_rst), 32'd1);
    check_eq("lock_e10_lock_ok", 32'(lock_ok), 32'd0);
    check_eq("lock_e10_state",   32'(state),   32'd1);
    tick(1);
    check_eq("lock_e11_sys_rst", 32'(sys_rst), 32'd0);
    check_eq("lock_e11_lock_ok", 32'(lock_ok), 32'd1);
    check_eq("lock_e11_state",   32'(state),   32'd2);

    // ---------------- loss in RUN with immediate relock ----------------
    locked = 1'b0;
    tick(2);
    check_eq("loss_e2_sys_rst", 32'(sys_rst), 32'd0);
    check_eq("loss_e2_cnt",     32'(lock_loss_cnt), 32'd0);
    tick(1);
    exp_cnt = 1;
    check_eq("loss_e3_sys_rst", 32'(sys_rst), 32'd1);
    check_eq("loss_e3_lock_ok", 32'(lock_ok), 32'd0);
    check_eq("loss_e3_state",   32'(state),   32'd3);
    check_eq("loss_e3_cnt",     32'(lock_loss_cnt), exp_view());
    locked = 1'b1;
    tick(3);
    check_eq("loss_e6_state", 32'(state), 32'd3);
    tick(1);
    check_eq("loss_e7_state", 32'(state), 32'd0);
    tick(1);
    check_eq("loss_e8_state", 32'(state), 32'd1);
    for (int e = 9; e <= 15; e++) begin
      tick(1);
      check_eq("loss_hold_sys_rst", 32'(sys_rst), 32'd1);
    end
    tick(1);
    check_eq("loss_e16_sys_rst", 32'(sys_rst), 32'd0);
    check_eq("loss_e16_state",   32'(state),   32'd2);
    check_eq("loss_e16_cnt",     32'(lock_loss_cnt), exp_view());

    // ---------------- saturation: 16 more losses (17 total) ----------------
    for (int k = 0; k < 16; k++) begin
      loss_and_relock("sat");
    end
    check_eq("sat_model", 32'(exp_cnt), 32'd15);
    check_eq("sat_final_cnt", 32'(lock_loss_cnt), exp_view());

    // ---------------- clear pulse ----------------
    clr_loss_cnt = 1'b1;
    tick(1);
    clr_loss_cnt = 1'b0;
    exp_cnt = 0;
    check_eq("clr_cnt",   32'(lock_loss_cnt), exp_view());
    check_eq("clr_state", 32'(state), 32'd2);

    // ---------------- clear coincident with a loss ----------------
    locked = 1'b0;
    tick(2);
    clr_loss_cnt = 1'b1;
    tick(1);
    clr_loss_cnt = 1'b0;
    exp_cnt = 1;
    check_eq("clrloss_state", 32'(state), 32'd3);
    check_eq("clrloss_cnt",   32'(lock_loss_cnt), exp_view());
    locked = 1'b1;
    tick(13);
    check_eq("clrloss_run_state", 32'(state), 32'd2);
    check_eq("clrloss_run_cnt",   32'(lock_loss_cnt), exp_view());

    // ---------------- mid-operation async reset ----------------
    RST_n = 1'b0;
    #2;
    exp_cnt = 0;
    check_eq("midrst_sys_rst", 32'(sys_rst), 32'd1);
    check_eq("midrst_lock_ok", 32'(lock_ok), 32'd0);
    check_eq("midrst_state",   32'(state),   32'd0);
    check_eq("midrst_cnt",     32'(lock_loss_cnt), 32'd0);
    locked = 1'b0;
    tick(2);
    RST_n = 1'b1;
    tick(3);
    check_eq("postrst_state", 32'(state), 32'd0);

    // ---------------- glitch during STABLE at count 5 ----------------
    locked = 1'b1;          // edge 0
    tick(6);
    locked = 1'b0;          // low for one cycle
    tick(1);
    locked = 1'b1;          // final rise at edge 7
    tick(1);
    check_eq("glitch_e8_state", 32'(state), 32'd1);
    tick(1);
    check_eq("glitch_e9_state", 32'(state), 32'd0);
    tick(1);
    check_eq("glitch_e10_state", 32'(state), 32'd1);
    for (int e = 11; e <= 17; e++) begin
      tick(1);
      check_eq("glitch_sys_rst", 32'(sys_rst), 32'd1);
    end
    tick(1);
    check_eq("glitch_e18_sys_rst", 32'(sys_rst), 32'd0);
    check_eq("glitch_e18_lock_ok", 32'(lock_ok), 32'd1);
    check_eq("glitch_e18_cnt",     32'(lock_loss_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
